// File: rtl/vdf_pkg.sv
// Shared definitions for the VDF squaring chain: FSM states, default widths
// and the modulus used by the multiplier and by reference models.
package vdf_pkg;

    localparam int DEF_BITS = 382;
    localparam int DEF_T_W  = 64;

    // Modulus for all squarings; operands are always reduced below this value.
    localparam logic [DEF_BITS-1:0] MODULUS = {1'b0, {(DEF_BITS-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/vdf_square_seq.sv
// Iterated-squaring sequencer: drives an external modular multiplier with
// a = b = current value T times, feeding each product back, and returns
// x^(2^T) mod MODULUS. One multiplier transaction is outstanding at a time.
module vdf_square_seq
    import vdf_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int T_W  = DEF_T_W
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_val,
    output logic            o_rdy,
    input  logic [BITS-1:0] i_x,
    input  logic [T_W-1:0]  i_t,
    output logic            o_val,
    input  logic            i_rdy,
    output logic [BITS-1:0] o_dat,
    output logic            o_busy,
    output logic [T_W-1:0]  o_iter,
    output logic            o_mul_val,
    input  logic            i_mul_rdy,
    output logic [BITS-1:0] o_mul_dat_a,
    output logic [BITS-1:0] o_mul_dat_b,
    input  logic            i_mul_val,
    output logic            o_mul_rdy,
    input  logic [BITS-1:0] i_mul_dat
);

    state_t          state;
    logic [BITS-1:0] cur;
    logic [T_W-1:0]  rem;

    // Handshake strobes are pure state decodes; o_mul_rdy stays high in IDLE
    // so a result left in flight by a reset is drained and dropped.
    assign o_rdy       = (state == IDLE);
    assign o_mul_val   = (state == ISSUE);
    assign o_mul_rdy   = (state == IDLE) || (state == WAIT);
    assign o_val       = (state == DONE);
    assign o_mul_dat_a = cur;
    assign o_mul_dat_b = cur;

    // Job FSM with remaining-count, progress counter and operand/result registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state  <= IDLE;
            cur    <= '0;
            rem    <= '0;
            o_iter <= '0;
            o_dat  <= '0;
            o_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_val) begin
                        cur    <= i_x;
                        rem    <= i_t;
                        o_iter <= '0;
                        o_busy <= 1'b1;
                        if (i_t == '0) begin
                            o_dat <= i_x;
                            state <= DONE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (i_mul_rdy) state <= WAIT;
                end
                WAIT: begin
                    if (i_mul_val) begin
                        cur    <= i_mul_dat;
                        rem    <= rem - T_W'(1);
                        o_iter <= o_iter + T_W'(1);
                        // rem is nonzero here, so the decrement cannot wrap
                        if (rem == T_W'(1)) begin
                            o_dat <= i_mul_dat;
                            state <= DONE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (i_rdy) begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vdf_square_seq.sv
// Directed bench for vdf_square_seq with a behavioural modular multiplier of
// configurable latency and optional random ready.
module tb_vdf_square_seq;
    import vdf_pkg::*;

    localparam int BITS = DEF_BITS;
    localparam int T_W  = DEF_T_W;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b0;
    logic            i_val = 1'b0;
    logic            o_rdy;
    logic [BITS-1:0] i_x = '0;
    logic [T_W-1:0]  i_t = '0;
    logic            o_val;
    logic            i_rdy = 1'b0;
    logic [BITS-1:0] o_dat;
    logic            o_busy;
    logic [T_W-1:0]  o_iter;
    logic            o_mul_val;
    logic            i_mul_rdy = 1'b1;
    logic [BITS-1:0] o_mul_dat_a;
    logic [BITS-1:0] o_mul_dat_b;
    logic            i_mul_val = 1'b0;
    logic            o_mul_rdy;
    logic [BITS-1:0] i_mul_dat = '0;

    vdf_square_seq #(.BITS(BITS), .T_W(T_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_val(i_val), .o_rdy(o_rdy), .i_x(i_x), .i_t(i_t),
        .o_val(o_val), .i_rdy(i_rdy), .o_dat(o_dat),
        .o_busy(o_busy), .o_iter(o_iter),
        .o_mul_val(o_mul_val), .i_mul_rdy(i_mul_rdy),
        .o_mul_dat_a(o_mul_dat_a), .o_mul_dat_b(o_mul_dat_b),
        .i_mul_val(i_mul_val), .o_mul_rdy(o_mul_rdy), .i_mul_dat(i_mul_dat)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- behavioural multiplier ----------------
    int              lat      = 5;
    bit              rnd_rdy  = 1'b0;
    bit              pend     = 1'b0;
    int              cnt      = 0;
    logic [BITS-1:0] res      = '0;
    int              txn      = 0;
    int              dup_err  = 0;
    int              stall_err = 0;
    int              ab_err   = 0;
    bit              prev_stall = 1'b0;
    logic [BITS-1:0] prev_a   = '0;
    logic [BITS-1:0] ops[$];

    function automatic logic [BITS-1:0] mulmod(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        logic [2*BITS-1:0] p;
        logic [2*BITS-1:0] m;
        p = {{BITS{1'b0}}, a} * {{BITS{1'b0}}, b};
        m = {{BITS{1'b0}}, MODULUS};
        p = p % m;
        return p[BITS-1:0];
    endfunction

    always @(posedge i_clk) begin
        if (i_mul_val && o_mul_rdy) i_mul_val <= 1'b0;
        if (o_mul_val && i_mul_rdy) begin
            if (pend || i_mul_val) dup_err <= dup_err + 1;
            pend <= 1'b1;
            cnt  <= lat;
            res  <= mulmod(o_mul_dat_a, o_mul_dat_b);
            ops.push_back(o_mul_dat_a);
            txn  <= txn + 1;
        end else if (pend) begin
            if (cnt <= 1) begin
                pend      <= 1'b0;
                i_mul_val <= 1'b1;
                i_mul_dat <= res;
            end else begin
                cnt <= cnt - 1;
            end
        end
        if (o_mul_val && (o_mul_dat_a != o_mul_dat_b)) ab_err <= ab_err + 1;
        if (prev_stall && (!o_mul_val || o_mul_dat_a != prev_a)) stall_err <= stall_err + 1;
        prev_stall <= o_mul_val && !i_mul_rdy;
        prev_a     <= o_mul_dat_a;
        i_mul_rdy  <= rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_job(input logic [BITS-1:0] x, input logic [T_W-1:0] t);
        int n = 0;
        while (!o_rdy && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        check("start_rdy", BITS'(o_rdy), BITS'(1));
        i_val = 1'b1;
        i_x   = x;
        i_t   = t;
        @(negedge i_clk);
        i_val = 1'b0;
        check("busy_after_accept", BITS'(o_busy), BITS'(1));
    endtask

    task automatic wait_result(input int hold, output logic [BITS-1:0] dat,
                               output logic [T_W-1:0] iter, output int cyc);
        bit stable = 1'b1;
        cyc = 0;
        while (!o_val && cyc < 2000) begin
            @(negedge i_clk);
            cyc++;
        end
        check("result_timeout", BITS'(o_val), BITS'(1));
        dat  = o_dat;
        iter = o_iter;
        for (int i = 0; i < hold; i++) begin
            @(negedge i_clk);
            if (!o_val || o_dat !== dat || !o_busy) stable = 1'b0;
        end
        if (hold > 0) check("hold_stable", BITS'(stable), BITS'(1));
        i_rdy = 1'b1;
        @(negedge i_clk);
        i_rdy = 1'b0;
        check("idle_after_ack", BITS'({o_busy, o_val, o_rdy}), BITS'(3'b001));
    endtask

    typedef struct {
        logic [BITS-1:0] x;
        logic [T_W-1:0]  t;
        int              hold;
        bit              rnd;
        logic [BITS-1:0] exp_dat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [BITS-1:0] dat;
        logic [T_W-1:0]  iter;
        int              cyc;
        int              t0;
        bit              quiet;

        vecs[0] = '{x: 3, t: 1, hold: 0, rnd: 0, exp_dat: 9};
        vecs[1] = '{x: 2, t: 3, hold: 0, rnd: 0, exp_dat: 256};
        vecs[2] = '{x: 5, t: 0, hold: 0, rnd: 0, exp_dat: 5};
        vecs[3] = '{x: 7, t: 4, hold: 10, rnd: 1, exp_dat: 382'd33232930569601};
        vecs[4] = '{x: 2, t: 6, hold: 2, rnd: 1, exp_dat: 382'd18446744073709551616};
        vecs[5] = '{x: MODULUS - 1, t: 1, hold: 0, rnd: 0, exp_dat: 1};
        vecs[6] = '{x: MODULUS - 2, t: 1, hold: 0, rnd: 0, exp_dat: 4};
        vecs[7] = '{x: 0, t: 5, hold: 0, rnd: 1, exp_dat: 0};

        // reset state
        repeat (3) @(negedge i_clk);
        check("rst_outputs", BITS'({o_val, o_mul_val, o_busy}), BITS'(0));
        check("rst_iter", BITS'(o_iter), BITS'(0));
        check("rst_dat", o_dat, '0);
        check("rst_mul_dat", o_mul_dat_a, '0);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("rdy_after_rst", BITS'(o_rdy), BITS'(1));

        // table-driven jobs
        for (int i = 0; i < 8; i++) begin
            rnd_rdy = vecs[i].rnd;
            ops.delete();
            t0 = txn;
            start_job(vecs[i].x, vecs[i].t);
            wait_result(vecs[i].hold, dat, iter, cyc);
            check($sformatf("dat[%0d]", i), dat, vecs[i].exp_dat);
            check($sformatf("iter[%0d]", i), BITS'(iter), BITS'(vecs[i].t));
            check($sformatf("txn[%0d]", i), BITS'(txn - t0), BITS'(vecs[i].t));
            if (vecs[i].t == 0) check("t0_latency", BITS'(cyc), BITS'(0));
            if (i == 1) begin
                check("op0", ops[0], 2);
                check("op1", ops[1], 4);
                check("op2", ops[2], 16);
            end
        end
        rnd_rdy = 1'b0;

        // reset during WAIT with a late multiplier result
        lat = 8;
        start_job(2, 10);
        cyc = 0;
        while (!pend && cyc < 100) begin
            @(negedge i_clk);
            cyc++;
        end
        check("reach_wait", BITS'(pend), BITS'(1));
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);
        check("midrst_ctrl", BITS'({o_val, o_mul_val, o_busy}), BITS'(0));
        check("midrst_dat", o_dat, '0);
        check("midrst_iter", BITS'(o_iter), BITS'(0));
        i_rst = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_val || o_busy || o_mul_val) quiet = 1'b0;
        end
        check("stray_result_dropped", BITS'(quiet), BITS'(1));
        check("stray_drained", BITS'({pend, i_mul_val}), BITS'(0));
        lat = 5;
        t0 = txn;
        start_job(3, 2);
        wait_result(0, dat, iter, cyc);
        check("post_rst_dat", dat, 81);
        check("post_rst_txn", BITS'(txn - t0), BITS'(2));

        // start request while busy is ignored
        t0 = txn;
        start_job(2, 3);
        repeat (3) @(negedge i_clk);
        check("rdy_low_busy", BITS'(o_rdy), BITS'(0));
        i_val = 1'b1;
        i_x   = 9;
        i_t   = 1;
        @(negedge i_clk);
        i_val = 1'b0;
        wait_result(0, dat, iter, cyc);
        check("busy_start_dat", dat, 256);
        check("busy_start_iter", BITS'(iter), BITS'(3));
        check("busy_start_txn", BITS'(txn - t0), BITS'(3));
        repeat (3) @(negedge i_clk);
        check("no_late_accept", BITS'(o_busy), BITS'(0));

        check("no_dup_issue", BITS'(dup_err), BITS'(0));
        check("operands_stable", BITS'(stall_err), BITS'(0));
        check("a_eq_b", BITS'(ab_err), BITS'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // overall time bound
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
